// File: rtl/sr595_chain_serializer.sv
`default_nettype none
// ============================================================================
// Module   : sr595_chain_serializer
// Purpose  : Shifts a snapshotted parallel word into a 74HC595 daisy chain
//            with a programmable SCLK divider, then pulses the shared latch.
// Revision : 1.0  initial release
// ============================================================================
module sr595_chain_serializer #(
    parameter int NUM_ICS      = 2,
    parameter int CLK_DIV      = 1,
    parameter int LATCH_CYCLES = 1
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   start_i,
    input  logic [NUM_ICS*8-1:0]   data_i,
    input  logic                   lsb_first_i,
    input  logic                   blank_i,
    output logic                   busy_o,
    output logic                   done_o,
    output logic                   sclk_o,
    output logic                   data_o,
    output logic                   latch_o,
    output logic                   oe_n_o
);

    localparam int C_N  = NUM_ICS * 8;
    localparam int C_BW = $clog2(C_N);
    localparam int C_DW = $clog2(CLK_DIV + 1);
    localparam int C_LW = $clog2(LATCH_CYCLES + 1);

    localparam logic [C_BW-1:0] C_LAST_BIT = C_BW'(C_N - 1);
    localparam logic [C_DW-1:0] C_DIV_LOAD = C_DW'(CLK_DIV - 1);
    localparam logic [C_LW-1:0] C_LAT_LOAD = C_LW'(LATCH_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SETUP = 3'd1,
        S_HIGH  = 3'd2,
        S_LATCH = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic [C_DW-1:0]  div_q, div_d;
    logic [C_LW-1:0]  lat_q, lat_d;
    logic [C_BW-1:0]  bit_q, bit_d;
    logic [C_N-1:0]   shadow_q, shadow_d;
    logic             lsb_q, lsb_d;
    logic             sclk_q, sclk_d;
    logic             data_q, data_d;
    logic             latch_q, latch_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             oe_n_q;
    logic [C_BW-1:0]  w_idx;

    always_comb begin
        state_d  = state_q;
        div_d    = div_q;
        lat_d    = lat_q;
        bit_d    = bit_q;
        shadow_d = shadow_q;
        lsb_d    = lsb_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                state_d = S_IDLE;
                if (start_i) begin
                    shadow_d = data_i;
                    lsb_d    = lsb_first_i;
                    bit_d    = '0;
                    div_d    = C_DIV_LOAD;
                    state_d  = S_SETUP;
                end
            end
            S_SETUP: begin
                if (div_q == '0) begin
                    div_d   = C_DIV_LOAD;
                    state_d = S_HIGH;
                end else begin
                    div_d = div_q - C_DW'(1);
                end
            end
            S_HIGH: begin
                if (div_q == '0) begin
                    div_d = C_DIV_LOAD;
                    if (bit_q == C_LAST_BIT) begin
                        lat_d   = C_LAT_LOAD;
                        state_d = S_LATCH;
                    end else begin
                        bit_d   = bit_q + C_BW'(1);
                        state_d = S_SETUP;
                    end
                end else begin
                    div_d = div_q - C_DW'(1);
                end
            end
            S_LATCH: begin
                if (lat_q == '0) begin
                    state_d = S_DONE;
                end else begin
                    lat_d = lat_q - C_LW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase

        // bit_q counts transmitted bits; the shadow index depends on bit order
        w_idx   = lsb_d ? bit_d : (C_LAST_BIT - bit_d);
        data_d  = (state_d == S_SETUP) ? shadow_d[w_idx] : data_q;
        sclk_d  = (state_d == S_HIGH);
        latch_d = (state_d == S_LATCH);
        busy_d  = (state_d == S_SETUP) || (state_d == S_HIGH) || (state_d == S_LATCH);
        done_d  = (state_d == S_DONE);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= S_IDLE;
            div_q    <= '0;
            lat_q    <= '0;
            bit_q    <= '0;
            shadow_q <= '0;
            lsb_q    <= 1'b0;
            sclk_q   <= 1'b0;
            data_q   <= 1'b0;
            latch_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            oe_n_q   <= 1'b1;
        end else begin
            state_q  <= state_d;
            div_q    <= div_d;
            lat_q    <= lat_d;
            bit_q    <= bit_d;
            shadow_q <= shadow_d;
            lsb_q    <= lsb_d;
            sclk_q   <= sclk_d;
            data_q   <= data_d;
            latch_q  <= latch_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            oe_n_q   <= blank_i;
        end
    end

    assign busy_o  = busy_q;
    assign done_o  = done_q;
    assign sclk_o  = sclk_q;
    assign data_o  = data_q;
    assign latch_o = latch_q;
    assign oe_n_o  = oe_n_q;

endmodule
`default_nettype wire

// File: tb/tb_sr595_chain_serializer.sv
`default_nettype none
// ============================================================================
// Module   : tb_sr595_chain_serializer
// Purpose  : Self-checking bench: a fast (D=1,L=1) and a slow (D=3,L=2) chain.
// Revision : 1.0  initial release
// ============================================================================
module tb_sr595_chain_serializer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, blank, lsb, start_f, start_s;
    logic [15:0] data;
    logic        sclk_f, dat_f, latch_f, busy_f, done_f, oen_f;
    logic        sclk_s, dat_s, latch_s, busy_s, done_s, oen_s;

    sr595_chain_serializer #(.NUM_ICS(2), .CLK_DIV(1), .LATCH_CYCLES(1)) u_fast (
        .clk_i(clk), .rst_i(rst), .start_i(start_f), .data_i(data),
        .lsb_first_i(lsb), .blank_i(blank), .busy_o(busy_f), .done_o(done_f),
        .sclk_o(sclk_f), .data_o(dat_f), .latch_o(latch_f), .oe_n_o(oen_f)
    );

    sr595_chain_serializer #(.NUM_ICS(2), .CLK_DIV(3), .LATCH_CYCLES(2)) u_slow (
        .clk_i(clk), .rst_i(rst), .start_i(start_s), .data_i(data),
        .lsb_first_i(lsb), .blank_i(blank), .busy_o(busy_s), .done_o(done_s),
        .sclk_o(sclk_s), .data_o(dat_s), .latch_o(latch_s), .oe_n_o(oen_s)
    );

    typedef struct {
        logic [15:0] din;
        logic        lsb_first;
        int          sel;
        logic [15:0] seq;   // expected shift order, first bit at [15]
    } vec_t;

    vec_t vecs[8];

    int n_chk = 0, n_pass = 0;
    int t = 0, t0 = 0, obs = 0;
    bit q0[$];
    bit q1[$];
    logic prev_s[2];
    logic prev_l;
    int low_run[2], high_run[2];
    int busy_n, latch_n, latch_first, latch_rises, done_n, done_at, rises, phase_bad;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0d)", name, act, exp, t);
    endtask

    function automatic logic [5:0] outs(input int sel);
        if (sel == 1) return {sclk_s, dat_s, latch_s, busy_s, done_s, oen_s};
        return {sclk_f, dat_f, latch_f, busy_f, done_f, oen_f};
    endfunction

    function automatic int divof(input int sel);
        return (sel == 1) ? 3 : 1;
    endfunction

    function automatic int latof(input int sel);
        return (sel == 1) ? 2 : 1;
    endfunction

    function automatic int qsize(input int sel);
        return (sel == 1) ? q1.size() : q0.size();
    endfunction

    task automatic push_word(input int sel, input logic [15:0] seq);
        for (int i = 15; i >= 0; i--) begin
            if (sel == 1) q1.push_back(seq[i]);
            else          q0.push_back(seq[i]);
        end
    endtask

    task automatic pop_exp(input int sel, output bit b);
        if (sel == 1) b = q1.pop_front();
        else          b = q0.pop_front();
    endtask

    task automatic mon(input int sel);
        logic [5:0] o;
        bit         e;
        int         d;
        o = outs(sel);
        d = divof(sel);
        if (rst) begin
            low_run[sel]  = 0;
            high_run[sel] = 0;
        end else begin
            if (o[5] && !prev_s[sel]) begin
                if (sel == obs) begin
                    rises++;
                    if (low_run[sel] != d) phase_bad++;
                end
                low_run[sel] = 0;
                if (qsize(sel) == 0) begin
                    n_chk++;
                    $display("FAIL sclk_unexpected: dut%0d rising SCLK with no pending bit (t=%0d)", sel, t);
                end else begin
                    pop_exp(sel, e);
                    chk("shift_bit", int'(o[4]), int'(e));
                end
            end
            if (!o[5] && prev_s[sel]) begin
                if (sel == obs && high_run[sel] != d) phase_bad++;
                high_run[sel] = 0;
            end
            if (o[5]) high_run[sel]++;
            else if (o[2] && !o[3]) low_run[sel]++;
            if (sel == obs) begin
                if (o[2]) busy_n++;
                if (o[3]) begin
                    if (latch_n == 0) latch_first = t - t0;
                    latch_n++;
                    if (!prev_l) latch_rises++;
                end
                if (o[1]) begin
                    done_n++;
                    done_at = t - t0;
                end
            end
        end
        if (sel == obs) prev_l = o[3];
        prev_s[sel] = o[5];
    endtask

    task automatic step();
        @(negedge clk);
        t++;
        mon(0);
        mon(1);
    endtask

    task automatic clear_stats(input int sel);
        obs = sel;
        busy_n = 0; latch_n = 0; latch_first = -1; latch_rises = 0;
        done_n = 0; done_at = -1; rises = 0; phase_bad = 0;
    endtask

    task automatic set_start(input int sel, input logic v);
        if (sel == 1) start_s = v;
        else          start_f = v;
    endtask

    task automatic run_vec(input vec_t v);
        int d, l;
        d = divof(v.sel);
        l = latof(v.sel);
        clear_stats(v.sel);
        data = v.din;
        lsb  = v.lsb_first;
        set_start(v.sel, 1'b1);
        push_word(v.sel, v.seq);
        t0 = t;
        step();
        set_start(v.sel, 1'b0);
        data = ~v.din;
        lsb  = ~v.lsb_first;
        for (int k = 0; k < 2*16*d + l + 20 && done_n == 0; k++) step();
        chk("done_seen",    done_n,      1);
        chk("done_at",      done_at,     1 + 2*16*d + l);
        chk("busy_cycles",  busy_n,      2*16*d + l);
        chk("latch_first",  latch_first, 1 + 2*16*d);
        chk("latch_cycles", latch_n,     l);
        chk("bits_left",    qsize(v.sel), 0);
        chk("sclk_phase",   phase_bad,   0);
        step();
    endtask

    initial begin
        vecs[0] = '{16'hA5C3, 1'b0, 0, 16'hA5C3};
        vecs[1] = '{16'hA5C3, 1'b1, 1, 16'hC3A5};
        vecs[2] = '{16'hA5C3, 1'b1, 0, 16'hC3A5};
        vecs[3] = '{16'hA5C3, 1'b0, 1, 16'hA5C3};
        vecs[4] = '{16'h1234, 1'b1, 0, 16'h2C48};
        vecs[5] = '{16'h8000, 1'b1, 1, 16'h0001};
        vecs[6] = '{16'hFFFF, 1'b0, 0, 16'hFFFF};
        vecs[7] = '{16'h0001, 1'b0, 0, 16'h0001};

        prev_s[0] = 1'b0; prev_s[1] = 1'b0; prev_l = 1'b0;
        low_run[0] = 0; low_run[1] = 0; high_run[0] = 0; high_run[1] = 0;
        rst = 1'b1; blank = 1'b0; lsb = 1'b0; start_f = 1'b0; start_s = 1'b0; data = '0;
        clear_stats(0);

        // reset values and output-enable latency
        repeat (3) step();
        chk("reset_outs_fast", int'(outs(0)), 6'b000001);
        chk("reset_outs_slow", int'(outs(1)), 6'b000001);
        rst = 1'b0;
        step();
        chk("oe_follow_fast", int'(outs(0)), 6'b000000);
        chk("oe_follow_slow", int'(outs(1)), 6'b000000);
        blank = 1'b1;
        step();
        chk("blank_on", int'(oen_f), 1);
        blank = 1'b0;
        step();
        chk("blank_off", int'(oen_s), 0);
        repeat (4) step();
        chk("idle_busy", int'({busy_f, busy_s}), 0);

        for (int i = 0; i < 8; i++) run_vec(vecs[i]);

        // start and new data mid-transfer must not disturb the shift
        clear_stats(0);
        data = 16'hA5C3; lsb = 1'b0; start_f = 1'b1;
        push_word(0, 16'hA5C3);
        t0 = t;
        step();
        start_f = 1'b0;
        while (t - t0 < 5) step();
        start_f = 1'b1; data = 16'hFFFF;
        step();
        start_f = 1'b0;
        for (int k = 0; k < 60 && done_n == 0; k++) step();
        repeat (5) step();
        chk("ign_done_count", done_n,  1);
        chk("ign_done_at",    done_at, 34);
        chk("ign_busy",       busy_n,  33);
        chk("ign_latch_at",   latch_first, 33);
        chk("ign_bits_left",  qsize(0), 0);

        // back-to-back with start held high
        clear_stats(0);
        data = 16'h0001; lsb = 1'b0; start_f = 1'b1;
        push_word(0, 16'h0001);
        push_word(0, 16'h0001);
        t0 = t;
        for (int k = 0; k < 60 && done_n == 0; k++) step();
        chk("b2b_first_done", done_at, 34);
        step();
        chk("b2b_no_gap", int'({sclk_f, dat_f, busy_f}), 3'b001);
        start_f = 1'b0;
        for (int k = 0; k < 60 && done_n < 2; k++) step();
        chk("b2b_second_done", done_at, 68);
        chk("b2b_latch_pulses", latch_rises, 2);
        chk("b2b_bits_left", qsize(0), 0);
        chk("b2b_phase", phase_bad, 0);
        step();

        // reset after bit 7, then a clean transfer
        clear_stats(0);
        data = 16'hA5C3; lsb = 1'b0; start_f = 1'b1;
        push_word(0, 16'hA5C3);
        t0 = t;
        step();
        start_f = 1'b0;
        for (int k = 0; k < 40 && rises < 8; k++) step();
        chk("rst_bits_before", rises, 8);
        rst = 1'b1;
        step();
        chk("rst_mid_outs", int'(outs(0)), 6'b000001);
        rst = 1'b0;
        q0.delete();
        repeat (4) step();
        chk("rst_no_latch", latch_rises + latch_n, 0);
        chk("rst_idle", int'({sclk_f, busy_f, done_f}), 0);
        run_vec(vecs[0]);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
